// File: rtl/mips_pipe_pkg.sv
// Shared pipeline types: register-address width, forwarding-mux select codes and the
// per-stage destination record carried alongside the pipeline registers.
package mips_pipe_pkg;

  localparam int unsigned RA_W = 5;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_M  = 2'b01;
  localparam logic [1:0] FWD_W  = 2'b10;

  typedef struct packed {
    logic [RA_W-1:0] dest;
    logic            wen;
    logic            load;
  } stage_rec_t;

endpackage

// File: rtl/hazard_match.sv
// Forwarding select for one source operand against the M and W destination records.
module hazard_match
  import mips_pipe_pkg::*;
#(
  parameter int unsigned ZERO_REG = 0
) (
  input  logic [RA_W-1:0] src,
  input  logic            use_src,
  input  stage_rec_t      m_rec,
  input  stage_rec_t      w_rec,
  output logic [1:0]      sel
);

  logic live;
  logic m_hit;
  logic w_hit;

  assign live  = use_src && (src != RA_W'(ZERO_REG));
  // A load in M has no data yet; only an ALU result there can be forwarded.
  assign m_hit = live && m_rec.wen && !m_rec.load && (m_rec.dest == src);
  assign w_hit = live && w_rec.wen && (w_rec.dest == src);

  always_comb begin
    sel = FWD_RF;
    if (m_hit) begin
      sel = FWD_M;
    end else if (w_hit) begin
      sel = FWD_W;
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Tracks in-flight E/M/W destinations and produces stall/bubble controls and the
// operand forwarding selects for the D and E stages.
module hazard_scoreboard #(
  parameter int unsigned RA_W     = mips_pipe_pkg::RA_W,
  parameter int unsigned ZERO_REG = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [RA_W-1:0] d_rs,
  input  logic [RA_W-1:0] d_rt,
  input  logic            d_use_rs,
  input  logic            d_use_rt,
  input  logic            d_early,
  input  logic [RA_W-1:0] d_dest,
  input  logic            d_wen,
  input  logic            d_load,
  output logic            stall,
  output logic            bubble_e,
  output logic [1:0]      fwd_d_rs,
  output logic [1:0]      fwd_d_rt,
  output logic [1:0]      fwd_e_rs,
  output logic [1:0]      fwd_e_rt,
  output logic [RA_W-1:0] w_dest,
  output logic            w_wen
);

  import mips_pipe_pkg::stage_rec_t;

  stage_rec_t      e_q, m_q, w_q;
  logic [RA_W-1:0] e_rs_q, e_rt_q;
  logic            e_use_rs_q, e_use_rt_q;

  function automatic logic rec_writes(stage_rec_t rec, logic [RA_W-1:0] r);
    return rec.wen && (rec.dest == r) && (r != RA_W'(ZERO_REG));
  endfunction

  logic rs_e_hit, rt_e_hit, rs_m_hit, rt_m_hit;
  logic rs_haz, rt_haz;

  assign rs_e_hit = rec_writes(e_q, d_rs);
  assign rt_e_hit = rec_writes(e_q, d_rt);
  assign rs_m_hit = rec_writes(m_q, d_rs);
  assign rt_m_hit = rec_writes(m_q, d_rt);

  // Early consumers cannot take anything from E; a load is not forwardable until W.
  assign rs_haz = d_use_rs && ((rs_e_hit && (e_q.load || d_early)) ||
                               (rs_m_hit && m_q.load && d_early));
  assign rt_haz = d_use_rt && ((rt_e_hit && (e_q.load || d_early)) ||
                               (rt_m_hit && m_q.load && d_early));

  assign stall    = rs_haz || rt_haz;
  assign bubble_e = stall;
  assign w_dest   = w_q.dest;
  assign w_wen    = w_q.wen;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_q        <= '0;
      m_q        <= '0;
      w_q        <= '0;
      e_rs_q     <= '0;
      e_rt_q     <= '0;
      e_use_rs_q <= 1'b0;
      e_use_rt_q <= 1'b0;
    end else begin
      w_q <= m_q;
      m_q <= e_q;
      if (stall) begin
        e_q        <= '0;
        e_rs_q     <= '0;
        e_rt_q     <= '0;
        e_use_rs_q <= 1'b0;
        e_use_rt_q <= 1'b0;
      end else begin
        e_q.dest   <= d_dest;
        e_q.wen    <= d_wen;
        e_q.load   <= d_load;
        e_rs_q     <= d_rs;
        e_rt_q     <= d_rt;
        e_use_rs_q <= d_use_rs;
        e_use_rt_q <= d_use_rt;
      end
    end
  end

  hazard_match #(.ZERO_REG(ZERO_REG)) u_match_d_rs (
    .src(d_rs), .use_src(d_use_rs), .m_rec(m_q), .w_rec(w_q), .sel(fwd_d_rs)
  );

  hazard_match #(.ZERO_REG(ZERO_REG)) u_match_d_rt (
    .src(d_rt), .use_src(d_use_rt), .m_rec(m_q), .w_rec(w_q), .sel(fwd_d_rt)
  );

  hazard_match #(.ZERO_REG(ZERO_REG)) u_match_e_rs (
    .src(e_rs_q), .use_src(e_use_rs_q), .m_rec(m_q), .w_rec(w_q), .sel(fwd_e_rs)
  );

  hazard_match #(.ZERO_REG(ZERO_REG)) u_match_e_rt (
    .src(e_rt_q), .use_src(e_use_rt_q), .m_rec(m_q), .w_rec(w_q), .sel(fwd_e_rt)
  );

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench: an instruction-level pipeline model predicts stall/forwarding each cycle.
module tb_hazard_scoreboard;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] d_rs, d_rt, d_dest;
  logic       d_use_rs, d_use_rt, d_early, d_wen, d_load;
  logic       stall, bubble_e, w_wen;
  logic [1:0] fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt;
  logic [4:0] w_dest;

  hazard_scoreboard #(.RA_W(5), .ZERO_REG(0)) dut (
    .clk(clk), .rst_n(rst_n),
    .d_rs(d_rs), .d_rt(d_rt), .d_use_rs(d_use_rs), .d_use_rt(d_use_rt),
    .d_early(d_early), .d_dest(d_dest), .d_wen(d_wen), .d_load(d_load),
    .stall(stall), .bubble_e(bubble_e),
    .fwd_d_rs(fwd_d_rs), .fwd_d_rt(fwd_d_rt), .fwd_e_rs(fwd_e_rs), .fwd_e_rt(fwd_e_rt),
    .w_dest(w_dest), .w_wen(w_wen)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: pipe[0]=E, pipe[1]=M, pipe[2]=W; each entry is a whole instruction.
  typedef struct {
    bit wen; bit load; int dest; int rs; int rt; bit use_rs; bit use_rt;
  } ins_t;

  typedef struct {
    int stall; int fdrs; int fdrt; int fers; int fert; int wdest; int wwen;
  } exp_t;

  ins_t pipe[3];
  exp_t sb_q[$];

  function automatic bit wr(ins_t i, int r);
    return i.wen && i.dest == r && r != 0;
  endfunction

  // Stage index (E=0,M=1,W=2) from which a producer's result can be forwarded.
  function automatic int ready_at(ins_t i);
    return i.load ? 2 : 1;
  endfunction

  // Consumer needs the value at its next stage (E), or right now in D if early.
  function automatic bit need_stall(int r, bit used, bit early);
    if (!used || r == 0) return 0;
    for (int p = 0; p < 3; p++)
      if (wr(pipe[p], r) && (p + (early ? 0 : 1)) < ready_at(pipe[p])) return 1;
    return 0;
  endfunction

  // Youngest producer whose result is available wins.
  function automatic int fwd_sel(int r, bit used);
    if (!used || r == 0) return 0;
    for (int p = 1; p < 3; p++)
      if (wr(pipe[p], r) && ready_at(pipe[p]) <= p) return (p == 1) ? 1 : 2;
    return 0;
  endfunction

  function automatic exp_t predict();
    exp_t e;
    e.stall = int'(need_stall(int'(d_rs), d_use_rs, d_early) ||
                   need_stall(int'(d_rt), d_use_rt, d_early));
    e.fdrs  = fwd_sel(int'(d_rs), d_use_rs);
    e.fdrt  = fwd_sel(int'(d_rt), d_use_rt);
    e.fers  = fwd_sel(pipe[0].rs, pipe[0].use_rs);
    e.fert  = fwd_sel(pipe[0].rt, pipe[0].use_rt);
    e.wdest = pipe[2].dest;
    e.wwen  = int'(pipe[2].wen);
    return e;
  endfunction

  function automatic void model_clear();
    for (int p = 0; p < 3; p++) pipe[p] = '{0, 0, 0, 0, 0, 0, 0};
  endfunction

  function automatic void advance(int stalled);
    pipe[2] = pipe[1];
    pipe[1] = pipe[0];
    if (stalled != 0) pipe[0] = '{0, 0, 0, 0, 0, 0, 0};
    else pipe[0] = '{d_wen, d_load, int'(d_dest), int'(d_rs), int'(d_rt), d_use_rs, d_use_rt};
  endfunction

  // Monitor: pops one prediction per cycle and compares against the DUT.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      chk("stall",    int'(stall),    e.stall);
      chk("bubble_e", int'(bubble_e), e.stall);
      chk("fwd_d_rs", int'(fwd_d_rs), e.fdrs);
      chk("fwd_d_rt", int'(fwd_d_rt), e.fdrt);
      chk("fwd_e_rs", int'(fwd_e_rs), e.fers);
      chk("fwd_e_rt", int'(fwd_e_rt), e.fert);
      chk("w_dest",   int'(w_dest),   e.wdest);
      chk("w_wen",    int'(w_wen),    e.wwen);
    end
  end

  task automatic set_d(input int rs, input int rt, input bit urs, input bit urt,
                       input bit early, input int dest, input bit wen, input bit load);
    d_rs = 5'(rs); d_rt = 5'(rt); d_use_rs = urs; d_use_rt = urt;
    d_early = early; d_dest = 5'(dest); d_wen = wen; d_load = load;
  endtask

  task automatic cycle(output bit dut_stall);
    exp_t e;
    bit   m_load_hit;
    e = predict();
    sb_q.push_back(e);
    // A load in M must never face an E consumer of its destination.
    m_load_hit = pipe[1].load && ((pipe[0].use_rs && wr(pipe[1], pipe[0].rs)) ||
                                  (pipe[0].use_rt && wr(pipe[1], pipe[0].rt)));
    chk("load_in_m_vs_e_src", int'(m_load_hit), 0);
    #3 dut_stall = stall;
    @(posedge clk);
    advance(e.stall);
    #1;
  endtask

  // Holds the instruction in D until it enters E; exp_stalls<0 means unchecked.
  task automatic issue(input int rs, input int rt, input bit urs, input bit urt,
                       input bit early, input int dest, input bit wen, input bit load,
                       input int exp_stalls);
    int n = 0;
    bit s, m;
    set_d(rs, rt, urs, urt, early, dest, wen, load);
    for (int k = 0; k < 4; k++) begin
      m = need_stall(rs, urs, early) || need_stall(rt, urt, early);
      cycle(s);
      if (s) n++;
      if (!m) break;
    end
    if (exp_stalls >= 0) chk("stall_cycles", n, exp_stalls);
  endtask

  task automatic nops(input int n);
    for (int i = 0; i < n; i++) issue(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  int regs[7] = '{0, 1, 8, 9, 10, 11, 31};

  task automatic rand_issue();
    issue(regs[$urandom_range(6)], regs[$urandom_range(6)], 1'($urandom_range(1)),
          1'($urandom_range(1)), ($urandom_range(3) == 0), regs[$urandom_range(6)],
          ($urandom_range(3) != 0), ($urandom_range(3) == 0), -1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    model_clear();
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      set_d($urandom_range(31), $urandom_range(31), 1'($urandom_range(1)),
            1'($urandom_range(1)), 1'($urandom_range(1)), $urandom_range(31),
            1'($urandom_range(1)), 1'($urandom_range(1)));
      #1;
      chk("rst_stall", int'(stall), 0);
      chk("rst_fwd_d", int'({fwd_d_rs, fwd_d_rt}), 0);
      chk("rst_fwd_e", int'({fwd_e_rs, fwd_e_rt}), 0);
      chk("rst_w", int'({w_dest, w_wen}), 0);
    end
    set_d(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Load-use: one bubble, then W forwarding into E.
    issue(0, 0, 0, 0, 0, 8, 1, 1, 0);
    issue(8, 0, 1, 0, 0, 13, 1, 0, 1);
    nops(3);
    // ALU chain: M forwarding then W forwarding.
    issue(0, 0, 0, 0, 0, 9, 1, 0, 0);
    issue(9, 9, 1, 1, 0, 14, 1, 0, 0);
    issue(9, 0, 1, 0, 0, 15, 1, 0, 0);
    nops(3);
    // Branch after ALU: 1 stall; branch after load: 2 stalls.
    issue(0, 0, 0, 0, 0, 10, 1, 0, 0);
    issue(10, 0, 1, 0, 1, 0, 0, 0, 1);
    nops(3);
    issue(0, 0, 0, 0, 0, 11, 1, 1, 0);
    issue(0, 11, 0, 1, 1, 0, 0, 0, 2);
    nops(3);
    // $zero never hazards.
    issue(0, 0, 0, 0, 0, 0, 1, 1, 0);
    issue(0, 0, 1, 1, 1, 0, 0, 0, 0);
    nops(3);
    // M beats W.
    issue(0, 0, 0, 0, 0, 12, 1, 0, 0);
    issue(0, 0, 0, 0, 0, 12, 1, 0, 0);
    issue(12, 0, 1, 0, 0, 16, 1, 0, 0);
    nops(3);
    // Unused source against jal's $31.
    issue(0, 0, 0, 0, 0, 31, 1, 0, 0);
    issue(0, 31, 0, 0, 0, 5, 1, 0, 0);
    nops(3);

    for (int i = 0; i < 300; i++) rand_issue();

    // Reset while stalled: stall must drop immediately.
    issue(0, 0, 0, 0, 0, 8, 1, 1, 0);
    set_d(8, 0, 1, 0, 0, 13, 1, 0);
    #2;
    chk("pre_reset_stall", int'(stall), 1);
    rst_n = 1'b0;
    #1;
    chk("mid_reset_stall", int'(stall), 0);
    chk("mid_reset_bubble", int'(bubble_e), 0);
    chk("mid_reset_w_wen", int'(w_wen), 0);
    model_clear();
    set_d(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 100; i++) rand_issue();
    nops(2);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Tracks the destination register chosen by the write-destination select (rt/rd/$31) as each instruction moves through the E, M and W stages of the 5-stage MIPS pipeline.
- Compares the D-stage and E-stage source registers against those in-flight destinations.
- Generates the stall/bubble controls and the 2-bit forwarding selects that drive the operand muxes. The select encoding matches the team's 3-input mux encoding.
- Sits beside the pipeline registers in the CPU top level.

Parameters:
- RA_W, 5, register-address width.
- ZERO_REG, 0, register index that never creates a hazard.

Ports:
- clk  input  1  pipeline clock.
- rst_n  input  1  asynchronous active-low reset.
- d_rs  input  RA_W  D-stage source register 1.
- d_rt  input  RA_W  D-stage source register 2.
- d_use_rs  input  1  D instruction reads rs.
- d_use_rt  input  1  D instruction reads rt.
- d_early  input  1  D instruction needs its operands in D (branch compare / jr).
- d_dest  input  RA_W  D-stage write destination, as produced by the destination select.
- d_wen  input  1  D instruction writes the register file.
- d_load  input  1  D instruction is a load (result ready only after M).
- stall  output  1  freeze PC and IF/ID.
- bubble_e  output  1  load a NOP into ID/EX.
- fwd_d_rs  output  2  D-operand select: 00 regfile, 01 from M, 10 from W.
- fwd_d_rt  output  2  same as fwd_d_rs, for rt.
- fwd_e_rs  output  2  E-operand select: 00 ID/EX value, 01 from M, 10 from W.
- fwd_e_rt  output  2  same as fwd_e_rs, for rt.
- w_dest  output  RA_W  destination of the W-stage record (debug/writeback check).
- w_wen  output  1  W-stage record writes.

Behaviour:
- Internal records E, M and W each hold {dest, wen, load}. E additionally holds {rs, rt, use_rs, use_rt}.
- rst_n low (async): all records cleared (wen=0, dest=0, load=0, use_*=0).
  - All outputs then read 0: stall=0, bubble_e=0, all fwd=00, w_dest=0, w_wen=0.
- A record "writes r" iff wen=1, dest==r and r!=ZERO_REG.
- Stall (combinational from current records and D inputs). Asserted if any of the following holds for a used D source r:
  - (a) E is a load writing r.
  - (b) d_early=1 and E writes r (any writer).
  - (c) d_early=1 and M is a load writing r.
- bubble_e = stall.
- Clock edge:
  - W<=M and M<=E, every cycle.
  - E<=D inputs when stall=0.
  - E<=cleared record when stall=1.
  - No instruction is lost; a stall lasts until the hazard record advances. Load-use costs 1 cycle. A branch after an ALU op costs 1 cycle. A branch after a load costs 2 cycles.
- D forwarding (combinational):
  - fwd_d_x=01 if M writes r and M is not a load.
  - else 10 if W writes r.
  - else 00.
  - Qualified by d_use_x; an unused source gives 00.
- E forwarding (combinational, from E.rs/E.rt):
  - 01 if M writes r and M is not a load.
  - else 10 if W writes r.
  - else 00.
  - A load in M matching E.r cannot occur because stall (a) prevents it. The verifier asserts this.
- Priority: M over W when both match (youngest value wins).
- ZERO_REG sources and destinations never stall or forward.
- Reset mid-stall: records clear immediately and stall drops the same instant.
- fwd value 11 is never produced.

Decomposition:
- Shared package mips_pipe_pkg holds:
  - RA_W.
  - FWD_RF=2'b00, FWD_M=2'b01, FWD_W=2'b10.
  - A stage_rec struct {dest, wen, load}.
- One sub-module is natural: hazard_match (combinational). Inputs are a source reg, its use flag and the M/W records; it returns the 2-bit select. It is instantiated four times.
- Stall logic and the record registers stay in the top module.

Test Plan:
- Reset: hold rst_n=0 with random inputs, then release → stall=0, all fwd=00, w_wen=0. Assert rst_n low mid-stall → stall drops within the same cycle.
- Load-use: lw $8 (d_dest=8, d_wen=1, d_load=1), next addu reading rs=8 → stall=1 and bubble_e=1 for exactly 1 cycle. Then fwd_e_rs=10 when addu is in E and lw is in W.
- ALU chain: addu $9; then subu reading rs=9, rt=9 → no stall, fwd_e_rs=fwd_e_rt=01. A third instruction reading 9 gets fwd_e_rs=10.
- Branch hazards: addu $10 then beq rs=10 with d_early=1 → 1 stall cycle, then fwd_d_rs=01. lw $11 then beq rt=11 → 2 stall cycles, then fwd_d_rt=10.
- $zero and priority:
  - Write to $0 followed by a reader of $0 → never stall, fwd=00.
  - addu $12; addu $12; reader of 12 → fwd_e_rs=01 (M beats W).
- Unused source: jal (d_dest=31) followed by an instruction with rt=31 and d_use_rt=0 → fwd_e_rt=00, stall=0.
